// File: rtl/counter_sequencer.sv
// Programmable timer built around a prescaled, bounded up-counter.
// A config handshake loads period / prescale / mode while the timer is idle.
// Commands start / pause / stop sequence it through IDLE, RUN, HOLD and DONE.
// An expiry pulse is raised each time the count reaches the programmed period.
//
// Handshake: a config beat transfers on any posedge where cfg_valid and cfg_ready
// are both high. cfg_ready is a pure function of state (high in IDLE/DONE) and
// does not depend on cfg_valid. While busy, cfg_valid is simply not accepted.
module counter_sequencer #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_period,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_periodic,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  stop,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  expire,
  output logic                  start_err,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state, state_next;
  logic [WIDTH-1:0]      period_reg;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic                  periodic_reg;
  logic [PRESCALE_W-1:0] pre_cnt;

  logic idle_like, active;
  logic cfg_fire, do_start, start_rej;
  logic cnt_en, tick, last_tick;

  // Per-cycle decode of commands against the current state.
  // Counting runs whenever the timer is active and neither stop nor pause is high,
  // so the cycle that drops pause already advances: a pause of N cycles costs N cycles.
  always_comb begin
    idle_like = (state == S_IDLE) || (state == S_DONE);
    active    = (state == S_RUN)  || (state == S_HOLD);
    cfg_fire  = cfg_valid && idle_like;
    // start is judged against the period held before any config landing this cycle
    do_start  = idle_like && start && (period_reg != '0);
    start_rej = idle_like && start && (period_reg == '0);
    cnt_en    = active && !stop && !pause;
    tick      = cnt_en && (pre_cnt == prescale_reg);
    last_tick = tick && (count == period_reg - WIDTH'(1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; stop outranks pause, which outranks a tick.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (do_start) state_next = S_RUN;
      end
      S_RUN: begin
        if (stop)                            state_next = S_IDLE;
        else if (pause)                      state_next = S_HOLD;
        else if (last_tick && !periodic_reg) state_next = S_DONE;
      end
      S_HOLD: begin
        if (stop)                            state_next = S_IDLE;
        else if (pause)                      state_next = S_HOLD;
        else if (last_tick && !periodic_reg) state_next = S_DONE;
        else                                 state_next = S_RUN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    busy      = active;
    cfg_ready = idle_like;
    state_dbg = state;
  end

  // Config latch, prescaler, tick counter and the one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_reg   <= '0;
      prescale_reg <= '0;
      periodic_reg <= 1'b0;
      pre_cnt      <= '0;
      count        <= '0;
      expire       <= 1'b0;
      start_err    <= 1'b0;
    end else begin
      expire    <= 1'b0;
      start_err <= 1'b0;
      if (cfg_fire) begin
        period_reg   <= cfg_period;
        prescale_reg <= cfg_prescale;
        periodic_reg <= cfg_periodic;
      end
      if (do_start) begin
        count   <= '0;
        pre_cnt <= '0;
      end else if (start_rej) begin
        start_err <= 1'b1;
      end else if (active && stop) begin
        // abort keeps the reached count visible, but the next run starts a fresh prescale window
        pre_cnt <= '0;
      end else if (cnt_en) begin
        if (tick) begin
          pre_cnt <= '0;
          if (last_tick) begin
            expire <= 1'b1;
            // one-shot parks at P; periodic reloads, so count never wraps
            count  <= periodic_reg ? '0 : period_reg;
          end else begin
            count <= count + WIDTH'(1);
          end
        end else begin
          pre_cnt <= pre_cnt + PRESCALE_W'(1);
        end
      end
    end
  end

endmodule
